// File: rtl/wormhole_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wormhole_output_arbiter
// Description : Two-stage switch arbiter with a per-output lock FSM. A packet's
//               head flit locks its output to one input port/VC until the tail
//               crosses, so packets never interleave on an output.
// Revision    : 1.0  initial release
// ============================================================================
module wormhole_output_arbiter #(
  parameter int PORT_NUM  = 5,
  parameter int VC_NUM    = 2,
  parameter int PORT_SIZE = $clog2(PORT_NUM),
  parameter int VC_SIZE   = $clog2(VC_NUM)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                head_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                tail_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]                grant_o,
  output logic [PORT_NUM-1:0][VC_SIZE-1:0]               vc_sel_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0]             xbar_sel_o,
  output logic [PORT_NUM-1:0]                            valid_flit_o,
  output logic [PORT_NUM-1:0]                            locked_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Per-output lock state and round-robin pointers
  state_e               state_q      [PORT_NUM];
  state_e               state_d      [PORT_NUM];
  logic [PORT_SIZE-1:0] owner_port_q [PORT_NUM];
  logic [PORT_SIZE-1:0] owner_port_d [PORT_NUM];
  logic [VC_SIZE-1:0]   owner_vc_q   [PORT_NUM];
  logic [VC_SIZE-1:0]   owner_vc_d   [PORT_NUM];
  logic [PORT_SIZE-1:0] out_ptr_q    [PORT_NUM];
  logic [PORT_SIZE-1:0] out_ptr_d    [PORT_NUM];
  // Per-input round-robin pointers
  logic [VC_SIZE-1:0]   in_ptr_q     [PORT_NUM];
  logic [VC_SIZE-1:0]   in_ptr_d     [PORT_NUM];

  // Arbitration intermediates
  logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
  logic [PORT_NUM-1:0]             cand_valid;
  logic [VC_SIZE-1:0]              cand_vc  [PORT_NUM];
  logic [PORT_SIZE-1:0]            cand_out [PORT_NUM];
  logic [PORT_NUM-1:0]             win_valid;
  logic [PORT_SIZE-1:0]            win_port [PORT_NUM];
  logic [VC_SIZE-1:0]              win_vc   [PORT_NUM];
  logic [PORT_NUM-1:0]             win_head;
  logic [PORT_NUM-1:0]             win_tail;
  logic [PORT_NUM-1:0]             port_won;

  // Eligibility: valid target, and head to an idle output or owner to a locked one
  always_comb begin
    elig = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        for (int o = 0; o < PORT_NUM; o++) begin
          if (request_i[p][v] && int'(out_port_i[p][v]) == o) begin
            if (state_q[o] == ST_IDLE) begin
              elig[p][v] = head_i[p][v];
            end else begin
              elig[p][v] = (int'(owner_port_q[o]) == p) && (int'(owner_vc_q[o]) == v);
            end
          end
        end
      end
    end
  end

  // Stage 1: one round-robin candidate VC per input port
  always_comb begin
    int idx;
    idx        = 0;
    cand_valid = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      cand_vc[p]  = '0;
      cand_out[p] = '0;
      for (int k = 0; k < VC_NUM; k++) begin
        idx = int'(in_ptr_q[p]) + k;
        if (idx >= VC_NUM) idx = idx - VC_NUM;
        if (!cand_valid[p] && elig[p][idx]) begin
          cand_valid[p] = 1'b1;
          cand_vc[p]    = VC_SIZE'(idx);
          cand_out[p]   = out_port_i[p][idx];
        end
      end
    end
  end

  // Stage 2: locked outputs take only their owner, idle outputs round-robin over inputs
  always_comb begin
    int idx;
    idx       = 0;
    win_valid = '0;
    win_head  = '0;
    win_tail  = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      win_port[o] = '0;
      win_vc[o]   = '0;
      if (state_q[o] == ST_LOCKED) begin
        for (int p = 0; p < PORT_NUM; p++) begin
          if (int'(owner_port_q[o]) == p && cand_valid[p] &&
              int'(cand_out[p]) == o && cand_vc[p] == owner_vc_q[o]) begin
            win_valid[o] = 1'b1;
            win_port[o]  = PORT_SIZE'(p);
            win_vc[o]    = cand_vc[p];
            win_head[o]  = head_i[p][cand_vc[p]];
            win_tail[o]  = tail_i[p][cand_vc[p]];
          end
        end
      end else begin
        for (int k = 0; k < PORT_NUM; k++) begin
          idx = int'(out_ptr_q[o]) + k;
          if (idx >= PORT_NUM) idx = idx - PORT_NUM;
          if (!win_valid[o] && cand_valid[idx] && int'(cand_out[idx]) == o) begin
            win_valid[o] = 1'b1;
            win_port[o]  = PORT_SIZE'(idx);
            win_vc[o]    = cand_vc[idx];
            win_head[o]  = head_i[idx][cand_vc[idx]];
            win_tail[o]  = tail_i[idx][cand_vc[idx]];
          end
        end
      end
      // Nothing is granted while reset is asserted
      if (rst) begin
        win_valid[o] = 1'b0;
      end
    end
  end

  // Output derivation from the stage-2 winners
  always_comb begin
    grant_o      = '0;
    vc_sel_o     = '0;
    xbar_sel_o   = '0;
    valid_flit_o = win_valid;
    port_won     = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (win_valid[o]) begin
        xbar_sel_o[o] = win_port[o];
        for (int p = 0; p < PORT_NUM; p++) begin
          if (int'(win_port[o]) == p) begin
            grant_o[p][win_vc[o]] = 1'b1;
            vc_sel_o[p]           = win_vc[o];
            port_won[p]           = 1'b1;
          end
        end
      end
    end
  end

  // Next-state: lock FSM transitions and pointer advance on grants only
  always_comb begin
    int nxt;
    nxt = 0;
    for (int p = 0; p < PORT_NUM; p++) begin
      in_ptr_d[p] = in_ptr_q[p];
      if (port_won[p]) begin
        nxt = int'(cand_vc[p]) + 1;
        if (nxt >= VC_NUM) nxt = 0;
        in_ptr_d[p] = VC_SIZE'(nxt);
      end
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      state_d[o]      = state_q[o];
      owner_port_d[o] = owner_port_q[o];
      owner_vc_d[o]   = owner_vc_q[o];
      out_ptr_d[o]    = out_ptr_q[o];
      if (win_valid[o]) begin
        if (state_q[o] == ST_IDLE) begin
          nxt = int'(win_port[o]) + 1;
          if (nxt >= PORT_NUM) nxt = 0;
          out_ptr_d[o] = PORT_SIZE'(nxt);
          // A HEADTAIL flit crosses without locking
          if (win_head[o] && !win_tail[o]) begin
            state_d[o]      = ST_LOCKED;
            owner_port_d[o] = win_port[o];
            owner_vc_d[o]   = win_vc[o];
          end
        end else if (win_tail[o]) begin
          state_d[o] = ST_IDLE;
        end
      end
    end
  end

  // State and pointer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        state_q[i]      <= ST_IDLE;
        owner_port_q[i] <= '0;
        owner_vc_q[i]   <= '0;
        out_ptr_q[i]    <= '0;
        in_ptr_q[i]     <= '0;
      end
    end else begin
      state_q      <= state_d;
      owner_port_q <= owner_port_d;
      owner_vc_q   <= owner_vc_d;
      out_ptr_q    <= out_ptr_d;
      in_ptr_q     <= in_ptr_d;
    end
  end

  // Lock status straight from the state register
  generate
    for (genvar o = 0; o < PORT_NUM; o++) begin : g_locked
      assign locked_o[o] = (state_q[o] == ST_LOCKED);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wormhole_output_arbiter.sv
`default_nettype none
// Testbench for wormhole_output_arbiter: directed vectors with a scoreboard
// queue of expected per-cycle responses, checked by an independent monitor.
module tb_wormhole_output_arbiter;
  localparam int P  = 5;
  localparam int V  = 2;
  localparam int PS = 3;
  localparam int VS = 1;

  logic clk = 1'b0;
  logic rst;
  logic [P-1:0][V-1:0]         request;
  logic [P-1:0][V-1:0][PS-1:0] out_port;
  logic [P-1:0][V-1:0]         head;
  logic [P-1:0][V-1:0]         tail;
  logic [P-1:0][V-1:0]         grant_o;
  logic [P-1:0][VS-1:0]        vc_sel_o;
  logic [P-1:0][PS-1:0]        xbar_sel_o;
  logic [P-1:0]                valid_flit_o;
  logic [P-1:0]                locked_o;

  typedef struct packed {
    logic [9:0]  g;
    logic [14:0] xb;
    logic [4:0]  vs;
    logic [4:0]  vf;
    logic [4:0]  lk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;
  int   mon_n  = 0;

  wormhole_output_arbiter #(.PORT_NUM(P), .VC_NUM(V)) dut (
    .clk          (clk),
    .rst          (rst),
    .request_i    (request),
    .out_port_i   (out_port),
    .head_i       (head),
    .tail_i       (tail),
    .grant_o      (grant_o),
    .vc_sel_o     (vc_sel_o),
    .xbar_sel_o   (xbar_sel_o),
    .valid_flit_o (valid_flit_o),
    .locked_o     (locked_o)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] gb(input int p, input int v);
    logic [9:0] r;
    r = '0;
    r[p*V+v] = 1'b1;
    return r;
  endfunction

  function automatic logic [14:0] xs(input int o, input int p);
    logic [14:0] r;
    r = '0;
    r[o*PS +: PS] = PS'(p);
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vector=%0d got=%h expected=%h", n, mon_n, got, want);
    end
  endtask

  task automatic clr();
    request  = '0;
    out_port = '0;
    head     = '0;
    tail     = '0;
  endtask

  task automatic add(input int p, input int v, input int o, input logic h, input logic t);
    request[p][v]  = 1'b1;
    out_port[p][v] = PS'(o);
    head[p][v]     = h;
    tail[p][v]     = t;
  endtask

  // Queue the expected response for the vector currently applied, then advance
  task automatic cyc(input logic [9:0] g, input logic [14:0] xb, input logic [4:0] vs,
                     input logic [4:0] vf, input logic [4:0] lk);
    exp_t e;
    e.g = g; e.xb = xb; e.vs = vs; e.vf = vf; e.lk = lk;
    exp_q.push_back(e);
    cyc_n++;
    @(posedge clk);
    #1;
    clr();
  endtask

  // Monitor: compares DUT outputs mid-cycle against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n++;
      chk("grant",  32'(grant_o),      32'(mon_e.g));
      chk("xbar",   32'(xbar_sel_o),   32'(mon_e.xb));
      chk("vc_sel", 32'(vc_sel_o),     32'(mon_e.vs));
      chk("valid",  32'(valid_flit_o), 32'(mon_e.vf));
      chk("locked", 32'(locked_o),     32'(mon_e.lk));
    end
  end

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    // Reset: requests are ignored while rst is high
    add(0, 0, 1, 1'b1, 1'b1);
    cyc('0, '0, '0, '0, '0);
    rst = 1'b0;

    // Single packet (0,0) -> output 2
    add(0, 0, 2, 1'b1, 1'b0); cyc(gb(0,0), '0, '0, 5'b00100, 5'b00000);
    add(0, 0, 2, 1'b0, 1'b0); cyc(gb(0,0), '0, '0, 5'b00100, 5'b00100);
    add(0, 0, 2, 1'b0, 1'b1); cyc(gb(0,0), '0, '0, 5'b00100, 5'b00100);
    cyc('0, '0, '0, '0, 5'b00000);

    // Lock holds output 1 for (0,0); (3,1) waits until after the tail
    add(0, 0, 1, 1'b1, 1'b0); cyc(gb(0,0), '0, '0, 5'b00010, 5'b00000);
    add(0, 0, 1, 1'b0, 1'b0); add(3, 1, 1, 1'b1, 1'b0);
    cyc(gb(0,0), '0, '0, 5'b00010, 5'b00010);
    add(3, 1, 1, 1'b1, 1'b0); cyc('0, '0, '0, '0, 5'b00010);
    add(0, 0, 1, 1'b0, 1'b1); add(3, 1, 1, 1'b1, 1'b0);
    cyc(gb(0,0), '0, '0, 5'b00010, 5'b00010);
    add(3, 1, 1, 1'b1, 1'b0); cyc(gb(3,1), xs(1,3), 5'b01000, 5'b00010, 5'b00000);
    cyc('0, '0, '0, '0, 5'b00010);
    add(3, 1, 1, 1'b0, 1'b1); cyc(gb(3,1), xs(1,3), 5'b01000, 5'b00010, 5'b00010);
    cyc('0, '0, '0, '0, 5'b00000);

    // Input round-robin on port 2: VC0 -> out3, VC1 -> out4
    for (int i = 0; i < 3; i++) begin
      add(2, 0, 3, 1'b1, 1'b1); add(2, 1, 4, 1'b1, 1'b1);
      if (i == 1) cyc(gb(2,1), xs(4,2), 5'b00100, 5'b10000, 5'b00000);
      else        cyc(gb(2,0), xs(3,2), 5'b00000, 5'b01000, 5'b00000);
    end

    // Output round-robin on output 0 among inputs 1, 2, 4
    for (int i = 0; i < 4; i++) begin
      add(1, 0, 0, 1'b1, 1'b1); add(2, 0, 0, 1'b1, 1'b1); add(4, 0, 0, 1'b1, 1'b1);
      case (i)
        0:       cyc(gb(1,0), xs(0,1), '0, 5'b00001, 5'b00000);
        1:       cyc(gb(2,0), xs(0,2), '0, 5'b00001, 5'b00000);
        2:       cyc(gb(4,0), xs(0,4), '0, 5'b00001, 5'b00000);
        default: cyc(gb(1,0), xs(0,1), '0, 5'b00001, 5'b00000);
      endcase
    end

    // Different inputs win different outputs in the same cycle
    add(0, 0, 2, 1'b1, 1'b1); add(1, 1, 3, 1'b1, 1'b1);
    cyc(gb(0,0) | gb(1,1), xs(3,1), 5'b00010, 5'b01100, 5'b00000);

    // Target output out of range is ignored
    add(1, 0, 6, 1'b1, 1'b1); cyc('0, '0, '0, '0, 5'b00000);

    // Body flit to an idle output: no grant, no lock
    add(4, 0, 2, 1'b0, 1'b0); cyc('0, '0, '0, '0, 5'b00000);
    cyc('0, '0, '0, '0, 5'b00000);

    // Mid-packet reset
    add(1, 0, 2, 1'b1, 1'b0); cyc(gb(1,0), xs(2,1), '0, 5'b00100, 5'b00000);
    rst = 1'b1;
    add(1, 0, 2, 1'b0, 1'b0); add(3, 0, 2, 1'b1, 1'b0);
    cyc('0, '0, '0, '0, 5'b00100);
    add(1, 0, 2, 1'b0, 1'b0); add(3, 0, 2, 1'b1, 1'b0);
    cyc('0, '0, '0, '0, 5'b00000);
    rst = 1'b0;
    add(1, 0, 2, 1'b0, 1'b0); add(3, 0, 2, 1'b1, 1'b0);
    cyc(gb(3,0), xs(2,3), '0, 5'b00100, 5'b00000);
    cyc('0, '0, '0, '0, 5'b00100);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
